// File: rtl/rhs_spi_slave_model.sv
// Behavioural RHS-style headstage SPI slave: oversampled mode-0 SPI, 32-bit command
// decode, register file, per-channel sample counters and a fixed-depth result pipeline.

module rhs_chan_ctr #(
  parameter logic [15:0] SEED = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= SEED;
    else if (clr) cnt <= SEED;
    else if (inc) cnt <= cnt + 16'd1;
  end
endmodule

module rhs_spi_slave_model #(
  parameter int          NUM_CHANNELS  = 16,
  parameter int          REG_DEPTH     = 64,
  parameter logic [15:0] STARTING_SEED = 16'd0,
  parameter int          PIPE_DEPTH    = 2,
  parameter logic [15:0] CHIP_ID       = 16'h0020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        frame_done,
  output logic [31:0] last_cmd,
  output logic [15:0] frame_count,
  output logic [7:0]  abort_count
);
  localparam int         CW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int         AW      = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [6:0] CH_LIM  = 7'(NUM_CHANNELS);
  localparam logic [8:0] REG_LIM = 9'(REG_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, EXEC} state_t;
  state_t state, state_d, prev_state;

  logic [1:0] cs_sync, sclk_sync, mosi_sync;
  logic       cs_q, sclk_q;
  logic       cs_s, sclk_s, mosi_s;
  logic       cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic       start, exec, abort;

  logic [31:0] shift_in, shift_out, result;
  logic [5:0]  bit_cnt;
  logic [PIPE_DEPTH-1:0][31:0]   pipe;
  logic [REG_DEPTH-1:0][15:0]    regs;
  logic [NUM_CHANNELS-1:0][15:0] cnt;
  logic [NUM_CHANNELS-1:0]       inc;

  logic [1:0]  op;
  logic [5:0]  ch;
  logic [7:0]  addr;
  logic [15:0] data, rd_val;
  logic        ch_ok, addr_ok, conv_hit, clr_hit;

  assign cs_s      = cs_sync[1];
  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign cs_fall   = cs_q & ~cs_s;
  assign cs_rise   = ~cs_q & cs_s;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;

  // cs_n idles high through reset so release never looks like a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync    <= 2'b11;
      sclk_sync  <= 2'b00;
      mosi_sync  <= 2'b00;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      state      <= IDLE;
      prev_state <= IDLE;
    end else begin
      cs_sync    <= {cs_sync[0], cs_n};
      sclk_sync  <= {sclk_sync[0], sclk};
      mosi_sync  <= {mosi_sync[0], mosi};
      cs_q       <= cs_s;
      sclk_q     <= sclk_s;
      state      <= state_d;
      prev_state <= state;
    end
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    exec    = 1'b0;
    abort   = 1'b0;
    case (state)
      // a cs fall during EXEC is already consumed by cs_q, so catch it via level here
      IDLE:  if (cs_fall || (!cs_s && prev_state == EXEC)) begin
               start   = 1'b1;
               state_d = SHIFT;
             end
      SHIFT: if (cs_rise) begin
               if (bit_cnt == 6'd32) state_d = EXEC;
               else begin
                 abort   = 1'b1;
                 state_d = IDLE;
               end
             end
      EXEC:  begin
               exec    = 1'b1;
               state_d = IDLE;
             end
      default: state_d = IDLE;
    endcase
  end

  assign op       = shift_in[31:30];
  assign ch       = shift_in[21:16];
  assign addr     = shift_in[23:16];
  assign data     = shift_in[15:0];
  assign ch_ok    = {1'b0, ch} < CH_LIM;
  assign addr_ok  = {1'b0, addr} < REG_LIM;
  assign conv_hit = exec && (op == 2'b00) && ch_ok;
  assign clr_hit  = exec && (op == 2'b01);

  always_comb begin
    rd_val = 16'h0000;
    if (addr_ok) rd_val = regs[addr[AW-1:0]];
    else begin
      case (addr)
        8'd251:  rd_val = 16'h494E;
        8'd252:  rd_val = 16'h5441;
        8'd253:  rd_val = 16'h4E00;
        8'd255:  rd_val = CHIP_ID;
        default: rd_val = 16'h0000;
      endcase
    end
  end

  always_comb begin
    result = 32'h0;
    case (op)
      2'b00:   if (ch_ok) result = {cnt[ch[CW-1:0]], 16'h0000};
      2'b10:   result = {16'hFFFF, data};
      2'b11:   result = {16'h0000, rd_val};
      default: result = 32'h0;
    endcase
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    localparam logic [15:0] SEED = STARTING_SEED + 16'(c);
    assign inc[c] = conv_hit && (ch == 6'(c));
    rhs_chan_ctr #(.SEED(SEED)) u_ctr (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr_hit),
      .inc  (inc[c]),
      .cnt  (cnt[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso        <= 1'b0;
      frame_done  <= 1'b0;
      last_cmd    <= 32'h0;
      frame_count <= 16'h0;
      abort_count <= 8'h0;
      shift_in    <= 32'h0;
      shift_out   <= 32'h0;
      bit_cnt     <= 6'd0;
      pipe        <= '0;
      regs        <= '0;
    end else begin
      frame_done <= exec;
      if (start) begin
        shift_out <= pipe[0];
        miso      <= pipe[0][31];
        bit_cnt   <= 6'd0;
      end
      if (state == SHIFT && !cs_rise) begin
        if (sclk_rise && bit_cnt < 6'd32) begin
          shift_in <= {shift_in[30:0], mosi_s};
          bit_cnt  <= bit_cnt + 6'd1;
        end
        if (sclk_fall) miso <= (bit_cnt < 6'd32) ? shift_out[5'd31 - bit_cnt[4:0]] : 1'b0;
      end
      if (abort) begin
        miso <= 1'b0;
        if (abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
      end
      if (exec) begin
        last_cmd    <= shift_in;
        frame_count <= frame_count + 16'd1;
        for (int i = 0; i < PIPE_DEPTH - 1; i++) pipe[i] <= pipe[i+1];
        pipe[PIPE_DEPTH-1] <= result;
        if (op == 2'b10 && addr_ok) regs[addr[AW-1:0]] <= data;
      end
    end
  end
endmodule

// File: tb/tb_rhs_spi_slave_model.sv
// Bench for rhs_spi_slave_model: directed frame table, abort/reset corners, then random
// frames scored against a queue-based model of the command set.

module tb_rhs_spi_slave_model;
  localparam int          NUM_CH = 16;
  localparam int          REG_D  = 64;
  localparam logic [15:0] SEED   = 16'hFFFE;
  localparam int          PD     = 2;
  localparam logic [15:0] CID    = 16'h0020;

  logic        clk = 1'b0;
  logic        rst_n, cs_n, sclk, mosi;
  logic        miso, frame_done;
  logic [31:0] last_cmd;
  logic [15:0] frame_count;
  logic [7:0]  abort_count;

  rhs_spi_slave_model #(
    .NUM_CHANNELS(NUM_CH), .REG_DEPTH(REG_D), .STARTING_SEED(SEED),
    .PIPE_DEPTH(PD), .CHIP_ID(CID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .frame_done(frame_done), .last_cmd(last_cmd),
    .frame_count(frame_count), .abort_count(abort_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, fd_cnt = 0;
  always @(posedge clk) if (frame_done) fd_cnt++;

  // reference model state
  logic [15:0] m_reg [REG_D];
  logic [15:0] m_cnt [NUM_CH];
  logic [31:0] m_pipe[$];
  int          m_frames, m_aborts, m_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < PD; i++) m_pipe.push_back(32'h0);
    for (int i = 0; i < REG_D; i++) m_reg[i] = 16'h0;
    for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 16'(SEED + 16'(c));
    m_frames = 0;
    m_aborts = 0;
  endtask

  function automatic logic [31:0] model_frame(input logic [31:0] cmd);
    logic [31:0] res = 32'h0;
    logic [31:0] head;
    int ch, addr;
    ch   = int'(cmd[21:16]);
    addr = int'(cmd[23:16]);
    case (cmd[31:30])
      2'b00: if (ch < NUM_CH) begin
               res = {m_cnt[ch], 16'h0};
               m_cnt[ch] = m_cnt[ch] + 16'd1;
             end
      2'b10: begin
               if (addr < REG_D) m_reg[addr] = cmd[15:0];
               res = {16'hFFFF, cmd[15:0]};
             end
      2'b11: begin
               if (addr < REG_D)    res = {16'h0, m_reg[addr]};
               else if (addr == 251) res = 32'h494E;
               else if (addr == 252) res = 32'h5441;
               else if (addr == 253) res = 32'h4E00;
               else if (addr == 255) res = {16'h0, CID};
             end
      default: for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 16'(SEED + 16'(c));
    endcase
    head = m_pipe.pop_front();
    m_pipe.push_back(res);
    m_frames++;
    m_total++;
    return head;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode-0 master: drive mosi after fall, sample miso just before rise
  task automatic spi_frame(input logic [31:0] tx, input int nbits, input bit raise,
                           output logic [31:0] rx);
    rx = 32'h0;
    cs_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[31-i];
      wait_clk(4);
      rx = {rx[30:0], miso};
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(4);
    mosi = 1'b0;
    if (raise) begin
      cs_n = 1'b1;
      wait_clk(8);
    end
  endtask

  task automatic full_frame(input string name, input logic [31:0] cmd);
    logic [31:0] rx, exp;
    spi_frame(cmd, 32, 1'b1, rx);
    exp = model_frame(cmd);
    chk(name, rx, exp);
    chk({name, "_fcnt"}, {16'h0, frame_count}, 32'(m_frames & 16'hFFFF));
    chk({name, "_last"}, last_cmd, cmd);
  endtask

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[22];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx, cmd;
    int nb;

    tbl[0]  = '{32'h0003_0000, 32'h0000_0000};
    tbl[1]  = '{32'h0003_0000, 32'h0000_0000};
    tbl[2]  = '{32'h0003_0000, 32'h0001_0000};
    tbl[3]  = '{32'h0001_0000, 32'h0002_0000};
    tbl[4]  = '{32'h0001_0000, 32'h0003_0000};
    tbl[5]  = '{32'hC0FB_0000, 32'hFFFF_0000};
    tbl[6]  = '{32'hC0FC_0000, 32'h0000_0000};
    tbl[7]  = '{32'hC0FD_0000, 32'h0000_494E};
    tbl[8]  = '{32'hC0FF_0000, 32'h0000_5441};
    tbl[9]  = '{32'h8005_BEEF, 32'h0000_4E00};
    tbl[10] = '{32'hC005_0000, 32'h0000_0020};
    tbl[11] = '{32'h80C8_1234, 32'hFFFF_BEEF};
    tbl[12] = '{32'hC0C8_0000, 32'h0000_BEEF};
    tbl[13] = '{32'h0014_0000, 32'hFFFF_1234};
    tbl[14] = '{32'h4000_0000, 32'h0000_0000};
    tbl[15] = '{32'h0003_0000, 32'h0000_0000};
    tbl[16] = '{32'hC03F_0000, 32'h0000_0000};
    tbl[17] = '{32'h803F_A5A5, 32'h0001_0000};
    tbl[18] = '{32'hC03F_0000, 32'h0000_0000};
    tbl[19] = '{32'hC040_0000, 32'hFFFF_A5A5};
    tbl[20] = '{32'h000F_0000, 32'h0000_A5A5};
    tbl[21] = '{32'h0010_0000, 32'h0000_0000};

    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    model_reset();
    wait_clk(3);
    chk("rst_miso",  {31'h0, miso}, 32'h0);
    chk("rst_fdone", {31'h0, frame_done}, 32'h0);
    chk("rst_last",  last_cmd, 32'h0);
    chk("rst_fcnt",  {16'h0, frame_count}, 32'h0);
    chk("rst_acnt",  {24'h0, abort_count}, 32'h0);
    rst_n = 1'b1;
    wait_clk(4);

    for (int i = 0; i < 22; i++) begin
      spi_frame(tbl[i].cmd, 32, 1'b1, rx);
      void'(model_frame(tbl[i].cmd));
      chk($sformatf("tbl%0d_miso", i), rx, tbl[i].exp);
      chk($sformatf("tbl%0d_fcnt", i), {16'h0, frame_count}, 32'(i + 1));
      chk($sformatf("tbl%0d_last", i), last_cmd, tbl[i].cmd);
    end

    // abort between two reads must not disturb pipeline order
    full_frame("ab_pre", 32'hC005_0000);
    spi_frame(32'hC03F_0000, 17, 1'b1, rx);
    m_aborts++;
    chk("ab_acnt", {24'h0, abort_count}, 32'd1);
    chk("ab_fcnt", {16'h0, frame_count}, 32'(m_frames));
    full_frame("ab_post", 32'hC03F_0000);
    full_frame("ab_d1", 32'h0010_0000);
    full_frame("ab_d2", 32'h0010_0000);

    // reset in the middle of a write while miso is driving a 1
    full_frame("rs_w", 32'h8005_0F0F);
    full_frame("rs_r", 32'hC005_0000);
    spi_frame(32'h8007_1111, 10, 1'b0, rx);
    chk("rs_pre_miso", {31'h0, miso}, {31'h0, m_pipe[0][21]});
    rst_n = 1'b0;
    #1;
    chk("rs_miso", {31'h0, miso}, 32'h0);
    chk("rs_fcnt", {16'h0, frame_count}, 32'h0);
    chk("rs_acnt", {24'h0, abort_count}, 32'h0);
    chk("rs_last", last_cmd, 32'h0);
    wait_clk(2);
    cs_n = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    model_reset();
    wait_clk(4);
    full_frame("rs_r5", 32'hC005_0000);
    full_frame("rs_r7", 32'hC007_0000);
    full_frame("rs_c3", 32'h0003_0000);
    full_frame("rs_d1", 32'hC0FF_0000);
    full_frame("rs_d2", 32'hC0FF_0000);

    // random traffic with occasional aborts
    for (int k = 0; k < 50; k++) begin
      cmd = $urandom;
      cmd[31:30] = 2'($urandom_range(0, 3));
      if (cmd[31:30] == 2'b01 && $urandom_range(0, 3) != 0) cmd[31:30] = 2'b11;
      if (cmd[31:30] == 2'b00) cmd[21:16] = 6'($urandom_range(0, 20));
      else if ($urandom_range(0, 9) < 7) cmd[23:16] = 8'($urandom_range(0, 70));
      else cmd[23:16] = 8'($urandom_range(250, 255));
      if ($urandom_range(0, 7) == 0) begin
        nb = $urandom_range(1, 31);
        spi_frame(cmd, nb, 1'b1, rx);
        if (m_aborts < 255) m_aborts++;
        chk("rnd_acnt", {24'h0, abort_count}, 32'(m_aborts));
      end else begin
        full_frame("rnd", cmd);
      end
    end

    chk("fdone_pulses", 32'(fd_cnt), 32'(m_total));
    chk("end_acnt", {24'h0, abort_count}, 32'(m_aborts));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rhs_spi_slave_model.md
Name: rhs_spi_slave_model

Overview:
- Parametrised behavioural SPI slave that emulates an RHS-style stimulation/recording headstage chip for bench and loopback testing of the headstage SPI master and cable-delay finder.
- Oversamples CS/SCLK/MOSI on the system clock and decodes 32-bit command frames (CONVERT, READ, WRITE, CLEAR).
- Maintains a register file and per-channel synthetic sample counters, and returns results on MISO with a configurable command pipeline latency.

Parameters:
- NUM_CHANNELS, 16: emulated amplifier channels, 1..32. CONVERT to a channel >= NUM_CHANNELS returns 0.
- REG_DEPTH, 64: writable 16-bit registers at addresses 0..REG_DEPTH-1, max 250.
- STARTING_SEED, 0: 16-bit initial value added to each channel counter.
- PIPE_DEPTH, 2: frames between a command and its result on MISO, 1..3.
- CHIP_ID, 16'h0020: value returned by READ of address 255.

Ports:
- clk, input, 1: system clock. Must be >= 4x SCLK, and SCLK high/low each >= 2 clk periods.
- rst_n, input, 1: asynchronous active-low reset.
- cs_n, input, 1: SPI chip select, active low, asynchronous to clk.
- sclk, input, 1: SPI clock, mode 0, asynchronous to clk.
- mosi, input, 1: SPI data in, MSB first.
- miso, output, 1: SPI data out, MSB first, registered.
- frame_done, output, 1: one-clk pulse after a complete 32-bit frame is accepted.
- last_cmd, output, 32: last accepted command word.
- frame_count, output, 16: accepted frames, wraps at 16'hFFFF -> 0.
- abort_count, output, 8: frames aborted by early CS rise, saturates at 255.

Behaviour:
- Reset (async assert, sync release):
  - miso=0, frame_done=0, last_cmd=0, frame_count=0, abort_count=0.
  - Registers 0..REG_DEPTH-1 = 0; channel counter[ch] = STARTING_SEED+ch (16-bit).
  - All PIPE_DEPTH response slots = 32'h0. FSM -> IDLE.
  - Reset asserted mid-frame discards the frame; no counters change.
- Synchronisation: cs_n, sclk and mosi each pass through a 2-flop synchroniser. Edges are detected on the synchronised sclk and cs_n.
- FSM:
  - IDLE: on a falling edge of synchronised cs_n, load shift_out = response slot at the head of the pipeline, drive miso = shift_out[31], set bit_cnt=0, go to SHIFT.
  - SHIFT:
    - sclk rise: shift_in = {shift_in[30:0], mosi_sync}; bit_cnt++.
    - sclk fall with bit_cnt < 32: miso = shift_out[31-bit_cnt].
    - After 32 bits, miso holds 0 and further edges are ignored.
    - cs_n rising edge: if bit_cnt == 32, go to EXEC; otherwise abort_count++, no state change, go to IDLE.
  - EXEC (1 clk): decode shift_in, push the result into the pipeline tail, pop the head, frame_done=1, frame_count++, last_cmd=shift_in, go to IDLE.
  - A cs_n fall seen in EXEC is handled in the following IDLE cycle. Synchronised cs_n remains low, so IDLE must treat "cs_n low and previous state EXEC" as a start.
- Decode on cmd[31:30]:
  - 00 CONVERT: ch = cmd[21:16].
    - ch < NUM_CHANNELS: result = {counter[ch], 16'h0000}, then counter[ch]++ with 16-bit wrap.
    - Otherwise result = 0.
  - 10 WRITE: addr = cmd[23:16], data = cmd[15:0].
    - addr < REG_DEPTH: reg[addr] = data.
    - Result = {16'hFFFF, data}, whether or not addr < REG_DEPTH.
  - 11 READ: addr = cmd[23:16]. Result = {16'h0000, val}, where val is:
    - reg[addr] if addr < REG_DEPTH
    - 251 -> 16'h494E, 252 -> 16'h5441, 253 -> 16'h4E00
    - 255 -> CHIP_ID
    - otherwise 0
  - 01 CLEAR: reset all channel counters to their seed values. Result = 32'h0000_0000.
- Pipeline: the result of frame N appears on MISO during frame N+PIPE_DEPTH. Aborted frames neither push nor pop.
- MISO timing: miso changes 3 clk after the physical sclk fall (2 sync + 1 reg). Master read margin is the master's concern.

Test Plan:
- Reset, then CONVERT ch3 (32'h0003_0000) x3 with PIPE_DEPTH=2, seed 0 -> MISO words 0, 0, 32'h0003_0000; 4th CONVERT ch3 frame returns 32'h0004_0000; frame_count=4.
- READ 251, 252, 253, 255, then 3 dummy CONVERTs -> MISO frames 3..6 = 32'h0000_494E, 32'h0000_5441, 32'h0000_4E00, 32'h0000_0020.
- WRITE reg 5 = 16'hBEEF, READ 5, 2 dummies -> frame 3 MISO = 32'hFFFF_BEEF, frame 4 = 32'h0000_BEEF; WRITE addr 200 -> 32'hFFFF_xxxx echoed, reg file unchanged.
- Frame aborted after 17 bits between two READs -> abort_count=1, frame_count excludes it, pipeline order unchanged.
- CONVERT ch 20 with NUM_CHANNELS=16 -> 0. Counter at 16'hFFFF wraps to 0. CLEAR restores seeds: STARTING_SEED=100, ch2 -> 32'h0066_0000.
- rst_n pulsed low at bit 10 of a WRITE -> miso=0 at once; reg file, counters and pipeline cleared; next full frame decodes normally.
